// File: rtl/memaccess_ctrl_pkg.sv
// Shared LC-3 memory-access definitions: mem_state codes, memory op encoding,
// controller FSM state codes and a small op-classification helper.
package lc3_mem_pkg;

    // mem_state codes understood by the memaccess datapath
    localparam logic [1:0] READ_MEM       = 2'd0;
    localparam logic [1:0] READ_MEM_INDIR = 2'd1;
    localparam logic [1:0] WRITE_MEM      = 2'd2;
    localparam logic [1:0] INIT_STATE     = 2'd3;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_LD   = 3'd1,
        OP_LDR  = 3'd2,
        OP_LDI  = 3'd3,
        OP_ST   = 3'd4,
        OP_STR  = 3'd5,
        OP_STI  = 3'd6,
        OP_RSVD = 3'd7
    } mem_op_e;

    // Controller FSM states
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PTR   = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;

    function automatic logic is_indirect(input mem_op_e op);
        return (op == OP_LDI) || (op == OP_STI);
    endfunction

endpackage

// File: rtl/memaccess_ctrl_if.sv
// Execute/memaccess/writeback-facing signal bundle of the memory-access sequencer.
interface memaccess_ctrl_if #(
    parameter int unsigned DATA_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_op;
    logic [1:0]        mem_state;
    logic              M_Control;
    logic [DATA_W-1:0] memout;
    logic              mem_stall;
    logic              done;
    logic [DATA_W-1:0] rd_data;
    logic              op_err;

    // Sequencer side
    modport slave (
        input  req_valid, req_op, memout,
        output req_ready, mem_state, M_Control, mem_stall, done, rd_data, op_err
    );

    // Environment side (execute/memaccess/writeback)
    modport master (
        output req_valid, req_op, memout,
        input  req_ready, mem_state, M_Control, mem_stall, done, rd_data, op_err
    );
endinterface

// File: rtl/memaccess_ctrl_wait_cnt.sv
// Phase timer: reloaded on entry to a memory phase, expires after WAIT_CYCLES+1 cycles.
module memaccess_wait_cnt #(
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_load,
    input  logic i_count,
    output logic o_expire
);
    localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    logic [CNT_W-1:0] r_cnt;

    assign o_expire = (r_cnt == CNT_W'(WAIT_CYCLES));

    // Count up within a phase and saturate at WAIT_CYCLES; never wraps
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= '0;
        end else if (i_count && !o_expire) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/memaccess_ctrl.sv
// LC-3 data-memory access sequencer: turns one accepted memory op into the
// mem_state / M_Control sequence, with indirect pointer phase, wait states and load capture.
module memaccess_ctrl
    import lc3_mem_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 0,
    parameter int unsigned DATA_W      = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    memaccess_ctrl_if.slave     bus
);
    logic [2:0]        r_state;
    logic [2:0]        w_state_next;
    mem_op_e           r_op;
    logic [DATA_W-1:0] r_rd_data;
    logic              w_xfer;
    logic              w_load;
    logic              w_expire;
    logic              w_in_phase;

    assign w_xfer     = bus.req_valid && bus.req_ready;
    assign w_in_phase = (r_state == S_PTR) || (r_state == S_READ) || (r_state == S_WRITE);

    memaccess_wait_cnt #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_cnt (
        .clock    (clock),
        .reset_n  (reset_n),
        .i_load   (w_load),
        .i_count  (w_in_phase),
        .o_expire (w_expire)
    );

    // Next state; w_load marks entry into any timed memory phase
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_xfer) begin
                    case (mem_op_e'(bus.req_op))
                        OP_LD, OP_LDR: begin
                            w_state_next = S_READ;
                            w_load       = 1'b1;
                        end
                        OP_ST, OP_STR: begin
                            w_state_next = S_WRITE;
                            w_load       = 1'b1;
                        end
                        OP_LDI, OP_STI: begin
                            w_state_next = S_PTR;
                            w_load       = 1'b1;
                        end
                        default: w_state_next = S_FIN;
                    endcase
                end
            end
            S_PTR: begin
                if (w_expire) begin
                    w_state_next = (r_op == OP_LDI) ? S_READ : S_WRITE;
                    w_load       = 1'b1;
                end
            end
            S_READ, S_WRITE: begin
                if (w_expire) begin
                    w_state_next = S_FIN;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // State register and op latch; op is frozen once the transfer is taken
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_op    <= OP_NONE;
        end else begin
            r_state <= w_state_next;
            if (w_xfer) begin
                r_op <= mem_op_e'(bus.req_op);
            end
        end
    end

    // Capture load data on the last cycle of the read phase
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_data <= '0;
        end else if ((r_state == S_READ) && w_expire) begin
            r_rd_data <= bus.memout;
        end
    end

    // Datapath control decoded from state and latched op only
    always_comb begin
        bus.mem_state = INIT_STATE;
        bus.M_Control = 1'b0;
        case (r_state)
            S_PTR: begin
                bus.mem_state = READ_MEM_INDIR;
                bus.M_Control = 1'b1;
            end
            S_READ: begin
                bus.mem_state = READ_MEM;
                bus.M_Control = is_indirect(r_op);
            end
            S_WRITE: begin
                bus.mem_state = WRITE_MEM;
                bus.M_Control = is_indirect(r_op);
            end
            default: ;
        endcase
    end

    assign bus.req_ready = (r_state == S_IDLE) && reset_n;
    assign bus.mem_stall = w_in_phase;
    assign bus.done      = (r_state == S_FIN);
    assign bus.op_err    = (r_state == S_FIN) && (r_op == OP_RSVD);
    assign bus.rd_data   = r_rd_data;
endmodule
